// File: rtl/trig_series.sv
// sin/cos evaluator: truncated Maclaurin series in Horner form on one shared
// fp multiplier and one shared fp adder, with start/busy/done handshake.

// Single-precision multiply. A one-cycle rst pulse starts it; the result is
// computed on the next cycle and done stays high until the next rst pulse.
// Denormals are flushed to zero; round to nearest even.
module trig_fp_mult (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] y
);
  logic        pend_q, pend_d, done_q, done_d;
  logic [31:0] y_q, y_d, prod;
  logic [47:0] p;
  logic signed [9:0] e;
  logic [22:0] m;
  logic [23:0] mr;
  logic        g, s, sign;

  always_comb begin
    sign = a[31] ^ b[31];
    p    = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e    = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) begin
      m = p[46:24];
      g = p[23];
      s = |p[22:0];
      e = e + 10'sd1;
    end else begin
      m = p[45:23];
      g = p[22];
      s = |p[21:0];
    end
    mr = {1'b0, m} + 24'(g & (s | m[0]));
    e  = e + $signed({9'd0, mr[23]});
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || e <= 10'sd0)
      prod = {sign, 31'd0};
    else if (e >= 10'sd255)
      prod = {sign, 8'hff, 23'd0};
    else
      prod = {sign, e[7:0], mr[22:0]};
  end

  always_comb begin
    pend_d = pend_q;
    done_d = done_q;
    y_d    = y_q;
    if (rst) begin
      pend_d = 1'b1;
      done_d = 1'b0;
    end else if (pend_q) begin
      pend_d = 1'b0;
      done_d = 1'b1;
      y_d    = prod;
    end
  end

  always_ff @(posedge clk) begin
    pend_q <= pend_d;
    done_q <= done_d;
    y_q    <= y_d;
  end

  assign done = done_q;
  assign y    = y_q;
endmodule

// Single-precision add with the same start/done behaviour as trig_fp_mult.
module trig_fp_add (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] y
);
  logic        pend_q, pend_d, done_q, done_d;
  logic [31:0] y_q, y_d, sum, big, sml;
  logic [7:0]  diff;
  logic [26:0] mb, ms, sh, dif, norm;
  logic [27:0] s28;
  logic [4:0]  lz;
  logic        found, g, st, is_zero;
  logic [23:0] mr;
  logic signed [9:0] e;

  always_comb begin
    if (b[30:0] > a[30:0]) begin
      big = b;
      sml = a;
    end else begin
      big = a;
      sml = b;
    end
    diff    = big[30:23] - sml[30:23];
    mb      = {1'b1, big[22:0], 3'b000};
    ms      = {1'b1, sml[22:0], 3'b000};
    e       = $signed({2'b00, big[30:23]});
    s28     = 28'd0;
    dif     = 27'd0;
    norm    = 27'd0;
    lz      = 5'd0;
    found   = 1'b0;
    is_zero = 1'b0;
    // Alignment keeps a sticky bit so round-to-nearest sees every shifted-out one
    if (diff >= 8'd27) begin
      sh = 27'd1;
    end else begin
      sh    = ms >> diff;
      sh[0] = sh[0] | (|(ms & ((27'd1 << diff) - 27'd1)));
    end
    if (big[31] == sml[31]) begin
      s28 = {1'b0, mb} + {1'b0, sh};
      if (s28[27]) begin
        norm = s28[27:1] | {26'd0, s28[0]};
        e    = e + 10'sd1;
      end else begin
        norm = s28[26:0];
      end
    end else begin
      dif = mb - sh;
      if (dif == 27'd0) is_zero = 1'b1;
      for (int i = 26; i >= 0; i--) begin
        if (!found) begin
          if (dif[i]) found = 1'b1;
          else        lz    = lz + 5'd1;
        end
      end
      norm = dif << lz;
      e    = e - $signed({5'd0, lz});
    end
    g  = norm[2];
    st = |norm[1:0];
    mr = {1'b0, norm[25:3]} + 24'(g & (st | norm[3]));
    e  = e + $signed({9'd0, mr[23]});
    if (sml[30:23] == 8'd0)
      sum = (big[30:23] == 8'd0) ? 32'd0 : big;
    else if (is_zero || e <= 10'sd0)
      sum = {big[31] & ~is_zero, 31'd0};
    else if (e >= 10'sd255)
      sum = {big[31], 8'hff, 23'd0};
    else
      sum = {big[31], e[7:0], mr[22:0]};
  end

  always_comb begin
    pend_d = pend_q;
    done_d = done_q;
    y_d    = y_q;
    if (rst) begin
      pend_d = 1'b1;
      done_d = 1'b0;
    end else if (pend_q) begin
      pend_d = 1'b0;
      done_d = 1'b1;
      y_d    = sum;
    end
  end

  always_ff @(posedge clk) begin
    pend_q <= pend_d;
    done_q <= done_d;
    y_q    <= y_d;
  end

  assign done = done_q;
  assign y    = y_q;
endmodule

// state  | meaning
// IDLE   | waiting for start
// SQUARE | x2 = theta*theta
// MUL    | acc = acc*x2
// ADD    | acc = acc + c[k]
// FINAL  | sin: result = acc*theta; cos: result = acc
// DONE   | one-cycle done pulse
module trig_series #(
  parameter int MAX_TERMS  = 8,
  parameter int WAIT_LIMIT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic [31:0] theta,
  input  logic [3:0]  prec,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        err
);
  localparam int          WW      = $clog2(WAIT_LIMIT + 1);
  localparam logic [3:0]  MAX_IDX = 4'(MAX_TERMS - 1);
  localparam logic [31:0] QNAN    = 32'h7fc00000;

  typedef enum logic [2:0] {S_IDLE, S_SQUARE, S_MUL, S_ADD, S_FINAL, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        issued_q, issued_d, mode_q, mode_d, err_q, err_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [3:0]  nm1_q, nm1_d, k_q, k_d;
  logic [31:0] theta_q, theta_d, x2_q, x2_d, acc_q, acc_d, result_q, result_d;
  logic [31:0] mult_a, mult_b, mult_y, add_y, coef_k;
  logic        go, op_state, core_done, mult_done, add_done, mult_rst, add_rst;

  // Terms past the eighth are not populated and read as zero.
  function automatic logic [31:0] coef(input logic m, input logic [3:0] k);
    case ({m, k})
      5'h00: coef = 32'h3f800000;
      5'h01: coef = 32'hbe2aaaab;
      5'h02: coef = 32'h3c088889;
      5'h03: coef = 32'hb9500d01;
      5'h04: coef = 32'h3638ef1d;
      5'h05: coef = 32'hb2d7322b;
      5'h06: coef = 32'h2f309231;
      5'h07: coef = 32'hab573f9f;
      5'h10: coef = 32'h3f800000;
      5'h11: coef = 32'hbf000000;
      5'h12: coef = 32'h3d2aaaab;
      5'h13: coef = 32'hbab60b61;
      5'h14: coef = 32'h37d00d01;
      5'h15: coef = 32'hb493f27e;
      5'h16: coef = 32'h310f76c7;
      5'h17: coef = 32'had49cba5;
      default: coef = 32'h00000000;
    endcase
  endfunction

  always_comb begin
    mult_a = theta_q;
    mult_b = theta_q;
    if (state_q == S_MUL) begin
      mult_a = acc_q;
      mult_b = x2_q;
    end else if (state_q == S_FINAL) begin
      mult_a = acc_q;
      mult_b = theta_q;
    end
  end

  assign coef_k    = coef(mode_q, k_q);
  assign op_state  = (state_q == S_SQUARE) || (state_q == S_MUL) || (state_q == S_ADD) ||
                     (state_q == S_FINAL && !mode_q);
  assign core_done = (state_q == S_ADD) ? add_done : mult_done;

  always_comb begin
    state_d  = state_q;
    issued_d = issued_q;
    wait_d   = wait_q;
    mode_d   = mode_q;
    theta_d  = theta_q;
    nm1_d    = nm1_q;
    k_d      = k_q;
    x2_d     = x2_q;
    acc_d    = acc_q;
    result_d = result_q;
    err_d    = err_q;
    go       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d   = mode;
          theta_d  = theta;
          issued_d = 1'b0;
          state_d  = S_SQUARE;
          if (prec > MAX_IDX) begin
            nm1_d = MAX_IDX;
            err_d = 1'b1;
          end else begin
            nm1_d = prec;
            err_d = 1'b0;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        if (state_q == S_FINAL && mode_q) begin
          result_d = acc_q;
          state_d  = S_DONE;
        end else if (op_state && !issued_q) begin
          go       = 1'b1;
          issued_d = 1'b1;
          wait_d   = WW'(WAIT_LIMIT);
        end else if (core_done) begin
          issued_d = 1'b0;
          case (state_q)
            S_SQUARE: begin
              x2_d  = mult_y;
              acc_d = coef(mode_q, nm1_q);
              k_d   = nm1_q - 4'd1;
              state_d = (nm1_q == 4'd0) ? S_FINAL : S_MUL;
            end
            S_MUL: begin
              acc_d   = mult_y;
              state_d = S_ADD;
            end
            S_ADD: begin
              acc_d = add_y;
              k_d   = k_q - 4'd1;
              state_d = (k_q == 4'd0) ? S_FINAL : S_MUL;
            end
            default: begin
              result_d = mult_y;
              state_d  = S_DONE;
            end
          endcase
        end else if (wait_q == '0) begin
          issued_d = 1'b0;
          err_d    = 1'b1;
          result_d = QNAN;
          state_d  = S_DONE;
        end else begin
          wait_d = wait_q - WW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      issued_q <= 1'b0;
      wait_q   <= '0;
      mode_q   <= 1'b0;
      theta_q  <= 32'd0;
      nm1_q    <= 4'd0;
      k_q      <= 4'd0;
      x2_q     <= 32'd0;
      acc_q    <= 32'd0;
      result_q <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      wait_q   <= wait_d;
      mode_q   <= mode_d;
      theta_q  <= theta_d;
      nm1_q    <= nm1_d;
      k_q      <= k_d;
      x2_q     <= x2_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Core starts are held off while the block itself is in reset.
  assign mult_rst = go && (state_q != S_ADD) && !reset;
  assign add_rst  = go && (state_q == S_ADD) && !reset;

  trig_fp_mult u_mult (.clk(clk), .rst(mult_rst), .a(mult_a), .b(mult_b), .done(mult_done), .y(mult_y));
  trig_fp_add  u_add  (.clk(clk), .rst(add_rst),  .a(acc_q),  .b(coef_k), .done(add_done),  .y(add_y));

  assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign err    = err_q;
endmodule

// File: tb/tb_trig_series.sv
// Self-checking bench for trig_series: scoreboard of expected results/latency
// pushed at start, popped and compared on each done pulse.
module tb_trig_series;
  localparam int MAX_TERMS = 8;
  localparam int LM = 3;  // mult core cycles incl. start cycle
  localparam int LA = 3;  // add core cycles incl. start cycle

  logic        clk = 1'b0;
  logic        reset, start, mode, busy, done, err;
  logic [31:0] theta, result;
  logic [3:0]  prec;

  typedef struct {
    logic [31:0] res;
    int          tol;
    logic        err;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  exp_t  mon_e;
  string mon_t;
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;

  trig_series #(.MAX_TERMS(MAX_TERMS), .WAIT_LIMIT(64)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .theta(theta),
    .prec(prec), .busy(busy), .done(done), .result(result), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp, input int tol);
    longint d;
    n_checks++;
    d = longint'({32'd0, got}) - longint'({32'd0, exp});
    if (d < 0) d = -d;
    if (d > longint'(tol)) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (tol %0d)", tag, got, exp, tol);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_done", 32'd1, 32'd0, 0);
      end else begin
        mon_e = sb_q.pop_front();
        mon_t = tag_q.pop_front();
        check_val({mon_t, "_result"}, result, mon_e.res, mon_e.tol);
        check_val({mon_t, "_err"}, {31'd0, err}, {31'd0, mon_e.err}, 0);
        check_val({mon_t, "_latency"}, 32'(cyc - mon_e.start_cyc), 32'(mon_e.lat), 0);
      end
    end
  end

  function automatic int latency(input logic m, input logic [3:0] p);
    int n;
    n = (int'(p) + 1 > MAX_TERMS) ? MAX_TERMS : int'(p) + 1;
    // edges from the accepting edge to the DONE cycle
    return LM + (n - 1) * (LM + LA) + (m ? 1 : LM) + 1;
  endfunction

  task automatic wait_done(input string tag, input bit poke_in_done);
    int cnt = 0;
    while (!done && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    if (!done) begin
      check_val({tag, "_timeout"}, 32'd0, 32'd1, 0);
    end else if (poke_in_done) begin
      start = 1'b1;
      @(negedge clk);
      check_val({tag, "_start_in_done_busy"}, {31'd0, busy}, 32'd0, 0);
      start = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic issue(input string tag, input logic m, input logic [31:0] th,
                       input logic [3:0] p, input logic [31:0] exp_res,
                       input int tol, input logic exp_err);
    exp_t e;
    e.res = exp_res;
    e.tol = tol;
    e.err = exp_err;
    e.lat = latency(m, p);
    e.start_cyc = cyc;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    mode = m;
    theta = th;
    prec = p;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_req(input string tag, input logic m, input logic [31:0] th,
                         input logic [3:0] p, input logic [31:0] exp_res,
                         input int tol, input logic exp_err, input bit poke);
    issue(tag, m, th, p, exp_res, tol, exp_err);
    wait_done(tag, poke);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; theta = 32'd0; prec = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy",   {31'd0, busy}, 32'd0, 0);
    check_val("rst_done",   {31'd0, done}, 32'd0, 0);
    check_val("rst_result", result,        32'd0, 0);
    check_val("rst_err",    {31'd0, err},  32'd0, 0);
    reset = 1'b0;
    @(negedge clk);

    run_req("sin0_p7",    1'b0, 32'h00000000, 4'd7,  32'h00000000, 0, 1'b0, 1'b0);
    run_req("cos0_p7",    1'b1, 32'h00000000, 4'd7,  32'h3f800000, 0, 1'b0, 1'b0);
    run_req("sin05_p5",   1'b0, 32'h3f000000, 4'd5,  32'h3ef57744, 2, 1'b0, 1'b0);
    run_req("cos05_p5",   1'b1, 32'h3f000000, 4'd5,  32'h3f60a940, 2, 1'b0, 1'b0);
    run_req("sin05_p0",   1'b0, 32'h3f000000, 4'd0,  32'h3f000000, 0, 1'b0, 1'b0);
    run_req("cos05_p0",   1'b1, 32'h3f000000, 4'd0,  32'h3f800000, 0, 1'b0, 1'b0);
    run_req("sin05_p15",  1'b0, 32'h3f000000, 4'd15, 32'h3ef57744, 2, 1'b1, 1'b1);
    run_req("sin05_p3",   1'b0, 32'h3f000000, 4'd3,  32'h3ef57744, 2, 1'b0, 1'b0);

    // starts with different inputs while busy must be ignored
    issue("busy_ign", 1'b0, 32'h3f000000, 4'd7, 32'h3ef57744, 2, 1'b0);
    check_val("busy_ign_busy", {31'd0, busy}, 32'd1, 0);
    for (int i = 0; i < 5; i++) begin
      mode = 1'b1; theta = 32'd0; prec = 4'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
    end
    wait_done("busy_ign", 1'b0);

    // reset during the first ADD: no done, outputs cleared
    mode = 1'b0; theta = 32'h3f000000; prec = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check_val("mid_add_busy_before", {31'd0, busy}, 32'd1, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("mid_rst_busy",   {31'd0, busy}, 32'd0, 0);
    check_val("mid_rst_done",   {31'd0, done}, 32'd0, 0);
    check_val("mid_rst_result", result,        32'd0, 0);
    repeat (20) @(negedge clk);
    check_val("mid_rst_idle_busy", {31'd0, busy}, 32'd0, 0);
    run_req("after_rst_cos05", 1'b1, 32'h3f000000, 4'd5, 32'h3f60a940, 2, 1'b0, 1'b0);

    repeat (10) @(negedge clk);
    check_val("sb_empty", 32'(sb_q.size()), 32'd0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
